dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder that sits on the far side of the load/store unit's memory interface: cs, wr, mask, addr, data_wr in; data_rd out.
- Holds a word-organised RAM and applies byte-lane masked writes.
- Returns full 32-bit words on reads; the load/store unit selects and extends bytes and halfwords.
- Adds a configurable wait-state engine and a stall output so the core can be held while an access completes.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words (power of two, ≥4).
- WAIT_CYCLES, 0, extra wait states per access (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cs  in  1  chip select, active-low; 1 = no access.
- wr  in  1  direction while cs=0: 1 = read (load), 0 = write (store).
- mask  in  4  byte-lane enables for writes; bit i enables data_wr[8i+7:8i]. Ignored for reads.
- addr  in  32  byte address; word index is addr[log2(DEPTH_WORDS)+1:2].
- data_wr  in  32  store data, already lane-aligned by the requester.
- data_rd  out  32  full read word.
- stall  out  1  high while an accepted access is incomplete; core holds its request.
- err  out  1  illegal-access pulse (see Optional Feature).

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: state=IDLE, wait counter=0, data_rd=0, err=0; stall=0 while rst is high.
  - RAM contents are not cleared.
  - Reset mid-access aborts it; a pending write is dropped and RAM is unchanged.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, cs=1: stay IDLE.
  - IDLE, cs=0: latch addr word index, wr, mask, data_wr. Load counter with WAIT_CYCLES. Next state is DONE if WAIT_CYCLES=0, otherwise WAIT.
  - WAIT: decrement counter each cycle; go to DONE when the counter reaches 1.
  - DONE: always return to IDLE.
- stall = (state==IDLE && cs==0) || state==WAIT, combinational. stall is 0 in DONE.
- Latency: request first seen in IDLE at cycle T, DONE at T+1+WAIT_CYCLES.
  - stall is high for 1+WAIT_CYCLES cycles.
  - Back-to-back accesses incur one IDLE cycle between them.
- Read: data_rd is registered on the edge entering DONE with RAM[latched index]. It holds until the next read enters DONE; writes do not change data_rd.
- Write: committed on the edge leaving DONE. Only lanes with latched mask[i]=1 are updated; all other lanes are preserved.
  - mask=0000 writes nothing.
- Address: bits above the index and addr[1:0] are ignored; accesses beyond DEPTH_WORDS wrap modulo DEPTH_WORDS.
- Request inputs are sampled only in IDLE. Changes on cs, addr or data during WAIT/DONE have no effect on the in-flight access.
- cs going high during WAIT does not cancel the access.
- Read-after-write to the same word in the next access returns the newly written data, because the write commits before the following access is latched.

Optional Feature:
- Macro: DMEM_MASK_CHK_EN.
- Defined:
  - Legal write masks are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - Any other mask on a write (including 0000) suppresses the RAM update. err is high for exactly the DONE cycle of that access.
  - Reads never flag.
- Not defined: err is tied to 0, and every mask pattern is written as given.

Test Plan:
- Word write then read (WAIT_CYCLES=0): write addr 0x10, mask 1111, data 0xDEADBEEF; then read addr 0x10. Required: stall high 1 cycle per access, data_rd=0xDEADBEEF in the read's DONE cycle.
- Byte lanes: preload 0x11223344 at 0x20. Write mask 0100, data_wr 0x00AA0000, then read. Required: data_rd=0x11AA3344. Then write mask 1100, data_wr 0xBBCC0000. Required: data_rd=0xBBCC3344.
- Wait states (WAIT_CYCLES=3): read request at cycle T. Required: stall high for cycles T..T+3, DONE at T+4, data valid at T+4. Toggling addr during stall does not change the result.
- Wrap-around (DEPTH_WORDS=1024): write 0x12345678 to addr 0x1000, read addr 0x0000. Required: data_rd=0x12345678.
- Reset mid-access (WAIT_CYCLES=2): issue write 0xCAFEF00D to 0x40 and assert rst during WAIT. Required: stall=0 and data_rd=0 immediately; a read of 0x40 after reset returns the prior contents.
- With DMEM_MASK_CHK_EN: write mask 0110, data 0xFFFFFFFF to a word holding 0x01020304. Required: err=1 for one cycle, RAM still 0x01020304. Without the macro: RAM becomes 0x01FFFF04 and err stays 0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between load/store unit and data memory
interface dmem_responder_if;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
  logic        err;

  modport master (
    output cs, wr, mask, addr, data_wr,
    input  data_rd, stall, err
  );

  modport slave (
    input  cs, wr, mask, addr, data_wr,
    output data_rd, stall, err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM responder with byte-lane writes, wait states and stall
// Optional write-mask legality check enabled by defining DMEM_MASK_CHK_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [3:0]      mask_q, mask_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q;
  logic            mask_ok;
  logic            we;
  logic            rd_en;

  logic [31:0]     mem [DEPTH_WORDS];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};

`ifdef DMEM_MASK_CHK_EN
  always_comb begin
    mask_ok = 1'b0;
    case (mask_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end
  assign bus.err = (state_q == S_DONE) && !wr_q && !mask_ok;
`else
  assign mask_ok = 1'b1;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (!bus.cs) begin
          idx_d   = bus.addr[AW+1:2];
          wr_d    = bus.wr;
          mask_d  = bus.mask;
          wdata_d = bus.data_wr;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read uses the _d view so a zero-wait access reads with the index being latched.
  assign rd_en = (state_d == S_DONE) && wr_d;
  assign we    = (state_q == S_DONE) && !wr_q && mask_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      if (rd_en) rdata_q <= mem[idx_d];
    end
  end

  // RAM is deliberately not reset; reset forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end

  assign bus.data_rd = rdata_q;
  assign bus.stall   = !rst && (((state_q == S_IDLE) && !bus.cs) || (state_q == S_WAIT));
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at WAIT_CYCLES 0, 3 and 2
module tb_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a   [3];
  logic        cs_a    [3];
  logic        wr_a    [3];
  logic [3:0]  mask_a  [3];
  logic [31:0] addr_a  [3];
  logic [31:0] dwr_a   [3];
  logic [31:0] dr_a    [3];
  logic        stall_a [3];
  logic        err_a   [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] model   [3][1024];
  logic [31:0] last_rd [3];
  logic [31:0] exp_q   [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder_if bus ();
    assign bus.cs      = cs_a[g];
    assign bus.wr      = wr_a[g];
    assign bus.mask    = mask_a[g];
    assign bus.addr    = addr_a[g];
    assign bus.data_wr = dwr_a[g];
    assign dr_a[g]     = bus.data_rd;
    assign stall_a[g]  = bus.stall;
    assign err_a[g]    = bus.err;

    dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES ((g == 0) ? 0 : (g == 1) ? 3 : 2)
    ) u_dut (
      .clk (clk),
      .rst (rst_a[g]),
      .bus (bus)
    );
  end

  function automatic int wc(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 3 : 2;
  endfunction

  function automatic logic legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_write(input int idx, input logic [3:0] m, input logic [31:0] a,
                             input logic [31:0] d);
    logic [31:0] w;
    w = model[idx][a[11:2]];
    for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    model[idx][a[11:2]] = w;
  endtask

  task automatic access(input int idx, input logic rd, input logic [3:0] m,
                        input logic [31:0] a, input logic [31:0] d, input logic toggle);
    int n;
    logic exp_err;
    logic [31:0] exp_rd;
    @(negedge clk);
    cs_a[idx] = 1'b0; wr_a[idx] = rd; mask_a[idx] = m; addr_a[idx] = a; dwr_a[idx] = d;
    exp_err = 1'b0;
`ifdef DMEM_MASK_CHK_EN
    exp_err = !rd && !legal(m);
`endif
    if (rd) exp_q.push_back(model[idx][a[11:2]]);
    else if (!exp_err) model_write(idx, m, a, d);
    #1;
    n = 0;
    while (stall_a[idx] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      cs_a[idx] = 1'b1;
      if (toggle) begin
        addr_a[idx] = $urandom; dwr_a[idx] = $urandom;
        mask_a[idx] = 4'($urandom); wr_a[idx] = 1'($urandom);
      end
      #1;
    end
    checks++;
    if (n !== 1 + wc(idx)) begin
      errors++;
      $display("FAIL stall_cycles u%0d addr=%h: got %0d, required %0d", idx, a, n, 1 + wc(idx));
    end
    checks++;
    if (err_a[idx] !== exp_err) begin
      errors++;
      $display("FAIL err_done u%0d addr=%h: got %b, required %b", idx, a, err_a[idx], exp_err);
    end
    if (rd) begin
      exp_rd = exp_q.pop_front();
      last_rd[idx] = exp_rd;
      checks++;
      if (dr_a[idx] !== exp_rd) begin
        errors++;
        $display("FAIL read_data u%0d addr=%h: got %h, required %h", idx, a, dr_a[idx], exp_rd);
      end
    end else begin
      checks++;
      if (dr_a[idx] !== last_rd[idx]) begin
        errors++;
        $display("FAIL rd_hold u%0d addr=%h: got %h, required %h", idx, a, dr_a[idx], last_rd[idx]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (err_a[idx] !== 1'b0) begin
      errors++;
      $display("FAIL err_after u%0d: got %b, required 0", idx, err_a[idx]);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst_a[i] = 1'b1; cs_a[i] = 1'b0; wr_a[i] = 1'b1; mask_a[i] = 4'hF;
      addr_a[i] = 32'h0; dwr_a[i] = 32'h0; last_rd[i] = 32'h0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stall_a[i] !== 1'b0) begin
        errors++; $display("FAIL reset_stall u%0d: got %b, required 0", i, stall_a[i]);
      end
      checks++;
      if (dr_a[i] !== 32'h0) begin
        errors++; $display("FAIL reset_data u%0d: got %h, required 00000000", i, dr_a[i]);
      end
      checks++;
      if (err_a[i] !== 1'b0) begin
        errors++; $display("FAIL reset_err u%0d: got %b, required 0", i, err_a[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cs_a[i] = 1'b1; rst_a[i] = 1'b0;
    end
  endtask

  task automatic test_word_rw();
    access(0, 1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    access(0, 1'b0, 4'hF, 32'h14, 32'h0BADF00D, 1'b0);
    access(0, 1'b1, 4'h0, 32'hFFFF_F013, 32'h0, 1'b0);
  endtask

  task automatic test_byte_lanes();
    access(0, 1'b0, 4'hF, 32'h20, 32'h11223344, 1'b0);
    access(0, 1'b0, 4'b0100, 32'h20, 32'h00AA0000, 1'b0);
    access(0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    access(0, 1'b0, 4'b1100, 32'h20, 32'hBBCC0000, 1'b0);
    access(0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
    access(0, 1'b0, 4'b0000, 32'h20, 32'hFFFFFFFF, 1'b0);
    access(0, 1'b1, 4'h0, 32'h20, 32'h0, 1'b0);
  endtask

  task automatic test_wait_states();
    access(1, 1'b0, 4'hF, 32'h30, 32'hA1B2C3D4, 1'b1);
    access(1, 1'b1, 4'h0, 32'h30, 32'h0, 1'b1);
    access(1, 1'b0, 4'b0011, 32'h34, 32'h00005566, 1'b1);
    access(1, 1'b1, 4'h0, 32'h34, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    access(0, 1'b0, 4'hF, 32'h1000, 32'h12345678, 1'b0);
    access(0, 1'b1, 4'h0, 32'h0000, 32'h0, 1'b0);
    access(0, 1'b0, 4'hF, 32'h0000_0FFC, 32'h9ABCDEF0, 1'b0);
    access(0, 1'b1, 4'h0, 32'h8000_1FFC, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    access(2, 1'b0, 4'hF, 32'h40, 32'h55667788, 1'b0);
    access(2, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
    @(negedge clk);
    cs_a[2] = 1'b0; wr_a[2] = 1'b0; mask_a[2] = 4'hF; addr_a[2] = 32'h40; dwr_a[2] = 32'hCAFEF00D;
    @(negedge clk);
    cs_a[2] = 1'b1;
    #1;
    checks++;
    if (stall_a[2] !== 1'b1) begin
      errors++; $display("FAIL mid_wait_stall: got %b, required 1", stall_a[2]);
    end
    #2 rst_a[2] = 1'b1;
    #1;
    checks++;
    if (stall_a[2] !== 1'b0) begin
      errors++; $display("FAIL mid_rst_stall: got %b, required 0", stall_a[2]);
    end
    checks++;
    if (dr_a[2] !== 32'h0) begin
      errors++; $display("FAIL mid_rst_data: got %h, required 00000000", dr_a[2]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_a[2] = 1'b0;
    last_rd[2] = 32'h0;
    access(2, 1'b1, 4'h0, 32'h40, 32'h0, 1'b0);
  endtask

  task automatic test_mask_chk();
    access(0, 1'b0, 4'hF, 32'h24, 32'h01020304, 1'b0);
    access(0, 1'b0, 4'b0110, 32'h24, 32'hFFFFFFFF, 1'b0);
    access(0, 1'b1, 4'h0, 32'h24, 32'h0, 1'b0);
    access(0, 1'b0, 4'b1010, 32'h24, 32'hEEEEEEEE, 1'b0);
    access(0, 1'b1, 4'h0, 32'h24, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    @(negedge clk);
    cs_a[0] = 1'b0; wr_a[0] = 1'b0; mask_a[0] = 4'hF; addr_a[0] = 32'h50; dwr_a[0] = 32'hA5A50F0F;
    model_write(0, 4'hF, 32'h50, 32'hA5A50F0F);
    #1;
    checks++;
    if (stall_a[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_stall_w: got %b, required 1", stall_a[0]);
    end
    @(negedge clk);
    wr_a[0] = 1'b1;
    #1;
    checks++;
    if (stall_a[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_stall_done: got %b, required 0", stall_a[0]);
    end
    @(negedge clk);
    exp_q.push_back(model[0][10'h14]);
    #1;
    checks++;
    if (stall_a[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_stall_r: got %b, required 1", stall_a[0]);
    end
    @(negedge clk);
    cs_a[0] = 1'b1;
    #1;
    exp_rd = exp_q.pop_front();
    last_rd[0] = exp_rd;
    checks++;
    if (dr_a[0] !== exp_rd) begin
      errors++; $display("FAIL b2b_raw: got %h, required %h", dr_a[0], exp_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_wait_states();
    test_wrap();
    test_reset_mid();
    test_mask_chk();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
